mul_product_accumulator: RTL and testbench
==========================================

Name: mul_product_accumulator

Overview:
- Sequential stage directly downstream of the 4x4 combinational array multiplier (mul4bits).
- Consumes its 16-bit product word through a valid/ready handshake.
- Accumulates N_TERMS consecutive products into a running sum, then presents the sum with a valid/ready output handshake.
- Turns the multiplier into a dot-product/MAC datapath for the lab's later experiments.

Parameters:
N_TERMS, 4, number of products summed per operation (>=1).
ACC_WIDTH, 16, accumulator/sum width in bits (>=16).

Ports:
Clock  input  1  single clock; all state updates on rising edge.
Reset  input  1  synchronous, active-low reset; sampled on rising edge of Clock.
iStart  input  1  starts a new accumulation; honoured only in IDLE.
iProduct  input  16  product word from mul4bits (bits [15:8] normally zero, still added).
iProductValid  input  1  iProduct is valid this cycle.
oProductReady  output  1  block accepts a product this cycle.
oSum  output  ACC_WIDTH  accumulated sum.
oSumValid  output  1  oSum is final and held.
iSumReady  input  1  consumer accepts oSum.
oOverflow  output  1  sticky; a carry out of ACC_WIDTH occurred during this operation.
oBusy  output  1  high in ACC and DONE.
oCount  output  clog2(N_TERMS+1)  products accepted in current operation.

Behaviour:
- Reset (Reset==0 at rising edge), from any state, including mid-operation:
  - State goes to IDLE.
  - oSum=0, oSumValid=0, oOverflow=0, oCount=0, oBusy=0, oProductReady=0.
  - Any partial sum is discarded.
- States are IDLE, ACC and DONE. oProductReady = (state==ACC); oBusy = (state!=IDLE); oSumValid = (state==DONE). All three decode directly from the registered state.
- IDLE:
  - iStart=1 -> ACC on the next edge.
  - On that same edge: accumulator<=0, oCount<=0, oOverflow<=0.
  - iProductValid is ignored; no transfer occurs.
- ACC:
  - A transfer occurs on an edge where iProductValid && oProductReady.
  - On a transfer: accumulator <= accumulator + zero-extended iProduct, computed ACC_WIDTH+1 wide, low ACC_WIDTH bits kept (modulo wrap).
  - If the carry bit is 1, oOverflow<=1. It stays set until the next start or reset.
  - On a transfer: oCount<=oCount+1.
  - A transfer with oCount==N_TERMS-1 moves to DONE on the same edge.
  - Gaps in iProductValid are allowed; the state is held.
  - iStart is ignored.
- Latency: oSumValid rises on the edge that accepts the N_TERMS-th product. It is visible in the cycle after that product was presented. With back-to-back products, a full operation takes N_TERMS cycles after entering ACC.
- oSum is the accumulator register, continuously driven. It is meaningful only while oSumValid=1.
- DONE:
  - oSum, oOverflow and oCount are held stable.
  - iSumReady=1 -> IDLE on the next edge, so oSumValid drops in the following cycle.
  - iStart is ignored, including when it is simultaneous with iSumReady; a new start requires a cycle in IDLE.
  - iProductValid is ignored.
- N_TERMS=1: the first transfer goes straight to DONE.
- Simultaneous Reset=0 with any other input: reset wins.
- No combinational path from any input to any output.

Decomposition:
- Shared package holds:
  - State encoding constants: IDLE=2'd0, ACC=2'd1, DONE=2'd2; 2'd3 is illegal and decodes to IDLE.
  - PRODUCT_WIDTH=16, shared with mul4bits' wResult width.
- No sub-module. The accumulator, counter and FSM sit in one module, with mul4bits instantiated alongside it at the next level up.

Test Plan:
1. Reset: hold Reset=0 for 2 cycles with random inputs -> all outputs 0, oProductReady=0.
2. Basic sum (N_TERMS=4): iStart pulse, then products 0x0009, 0x00E1, 0x0001, 0x0000 back-to-back.
   - oSumValid=1 in the cycle after the 4th product.
   - oSum=0x00EB, oOverflow=0, oCount=4.
3. Handshake gaps: iProductValid=1 with iProduct=0x0010 while in IDLE (must be ignored). Then start and send 0x0002, 0x0003, 0x0004, 0x0005 with 1-3 idle cycles between them -> oSum=0x000E, oCount=4.
4. Overflow: products 0x8000, 0x8000, 0x0001, 0x0000 -> oSum=0x0001, oOverflow=1. The next operation with small products -> oOverflow=0.
5. Output backpressure: hold iSumReady=0 for 5 cycles in DONE, pulsing iStart and iProductValid.
   - oSum, oCount and oSumValid stay unchanged.
   - Then iSumReady=1 -> IDLE next cycle, oSumValid=0, oBusy=0.
6. Reset mid-op: after 2 accepted products, Reset=0 for one cycle -> IDLE with all outputs 0. A fresh operation with 1, 1, 1, 1 -> oSum=0x0004, unaffected by the discarded partial sum.

Source files
------------

// File: rtl/mul_product_accumulator_pkg.sv
// Shared definitions for the product accumulator that sits behind mul4bits.
// State encoding and the multiplier's product width live here.
package mul_product_accumulator_pkg;

  localparam int PRODUCT_WIDTH = 16;

  // 2'd3 is never entered; the FSM treats it as IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mul_product_accumulator_if.sv
// Product-in / sum-out handshake bundle for mul_product_accumulator.
// The slave side is the accumulator; the master side is the surrounding datapath.
interface mul_product_accumulator_if
  import mul_product_accumulator_pkg::*;
#(
  parameter int ACC_WIDTH = 16,
  parameter int CNT_WIDTH = 3
);

  logic                     iStart;
  logic [PRODUCT_WIDTH-1:0] iProduct;
  logic                     iProductValid;
  logic                     oProductReady;
  logic [ACC_WIDTH-1:0]     oSum;
  logic                     oSumValid;
  logic                     iSumReady;
  logic                     oOverflow;
  logic                     oBusy;
  logic [CNT_WIDTH-1:0]     oCount;

  modport slave (
    input  iStart, iProduct, iProductValid, iSumReady,
    output oProductReady, oSum, oSumValid, oOverflow, oBusy, oCount
  );

  modport master (
    output iStart, iProduct, iProductValid, iSumReady,
    input  oProductReady, oSum, oSumValid, oOverflow, oBusy, oCount
  );

endinterface

// File: rtl/mul_product_accumulator.sv
// Sums N_TERMS consecutive mul4bits products and presents the result with
// a valid/ready handshake; overflow flag is sticky for the operation.
//
// state | meaning
// IDLE  | waiting for iStart; last result still visible on oSum
// ACC   | accepting products until N_TERMS have been summed
// DONE  | result held until the consumer asserts iSumReady
module mul_product_accumulator
  import mul_product_accumulator_pkg::*;
#(
  parameter int N_TERMS   = 4,
  parameter int ACC_WIDTH = 16,
  localparam int CNT_WIDTH = $clog2(N_TERMS + 1)
) (
  input  logic                       Clock,
  input  logic                       Reset,
  mul_product_accumulator_if.slave   bus
);

  state_t               state;
  logic [ACC_WIDTH-1:0] acc;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 ovf;
  logic [ACC_WIDTH:0]   sum_ext;

  // One extra bit so the carry out of the accumulator is visible.
  assign sum_ext = {1'b0, acc}
                 + {{(ACC_WIDTH + 1 - PRODUCT_WIDTH){1'b0}}, bus.iProduct};

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.iStart) begin
            state <= ACC;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
          end
        end
        ACC: begin
          if (bus.iProductValid) begin
            acc <= sum_ext[ACC_WIDTH-1:0];
            cnt <= cnt + CNT_WIDTH'(1);
            if (sum_ext[ACC_WIDTH]) ovf <= 1'b1;
            if (cnt == CNT_WIDTH'(N_TERMS - 1)) state <= DONE;
          end
        end
        DONE: begin
          if (bus.iSumReady) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.oProductReady = (state == ACC);
  assign bus.oSumValid     = (state == DONE);
  assign bus.oBusy         = (state == ACC) || (state == DONE);
  assign bus.oSum          = acc;
  assign bus.oOverflow     = ovf;
  assign bus.oCount        = cnt;

endmodule

// File: tb/tb_mul_product_accumulator.sv
// Directed bench for mul_product_accumulator: stimulus pushes expected
// results, a negedge monitor checks each completed sum as it appears.
module tb_mul_product_accumulator;
  import mul_product_accumulator_pkg::*;

  localparam int N_TERMS   = 4;
  localparam int ACC_WIDTH = 16;
  localparam int CNT_WIDTH = $clog2(N_TERMS + 1);

  typedef struct {
    logic [ACC_WIDTH-1:0] sum;
    logic                 ovf;
    logic [CNT_WIDTH-1:0] cnt;
  } exp_t;

  logic Clock = 1'b0;
  logic Reset = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t exp_q[$];
  logic prev_valid = 1'b0;

  mul_product_accumulator_if #(.ACC_WIDTH(ACC_WIDTH), .CNT_WIDTH(CNT_WIDTH)) bus ();

  mul_product_accumulator #(.N_TERMS(N_TERMS), .ACC_WIDTH(ACC_WIDTH)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: compare each sum when oSumValid first rises.
  always @(negedge Clock) begin
    if (bus.oSumValid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_sum", 32'(bus.oSum), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_sum", 32'(bus.oSum), 32'(e.sum));
        check("sb_ovf", 32'(bus.oOverflow), 32'(e.ovf));
        check("sb_cnt", 32'(bus.oCount), 32'(e.cnt));
      end
    end
    prev_valid = bus.oSumValid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic start_op();
    bus.iStart = 1'b1;
    step();
    bus.iStart = 1'b0;
  endtask

  task automatic send(input logic [15:0] p, input int gap);
    for (int g = 0; g < gap; g++) begin
      bus.iProductValid = 1'b0;
      bus.iProduct      = 16'hDEAD;
      step();
    end
    bus.iProductValid = 1'b1;
    bus.iProduct      = p;
    step();
    bus.iProductValid = 1'b0;
  endtask

  task automatic push(input logic [15:0] s, input logic o);
    exp_t e;
    e.sum = s;
    e.ovf = o;
    e.cnt = CNT_WIDTH'(N_TERMS);
    exp_q.push_back(e);
  endtask

  task automatic release_sum();
    bus.iSumReady = 1'b1;
    step();
    bus.iSumReady = 1'b0;
    check("release_valid", 32'(bus.oSumValid), 32'd0);
    check("release_busy", 32'(bus.oBusy), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_sum"},   32'(bus.oSum), 32'd0);
    check({tag, "_valid"}, 32'(bus.oSumValid), 32'd0);
    check({tag, "_ovf"},   32'(bus.oOverflow), 32'd0);
    check({tag, "_cnt"},   32'(bus.oCount), 32'd0);
    check({tag, "_busy"},  32'(bus.oBusy), 32'd0);
    check({tag, "_ready"}, 32'(bus.oProductReady), 32'd0);
  endtask

  initial begin
    bus.iStart = 1'b0;
    bus.iProduct = '0;
    bus.iProductValid = 1'b0;
    bus.iSumReady = 1'b0;

    // 1: reset with random inputs
    Reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.iStart        = 1'($urandom);
      bus.iProduct      = 16'($urandom);
      bus.iProductValid = 1'($urandom);
      bus.iSumReady     = 1'($urandom);
      step();
    end
    check_all_zero("reset");
    bus.iStart = 1'b0; bus.iProductValid = 1'b0; bus.iSumReady = 1'b0;
    Reset = 1'b1;
    step();

    // 2: basic back-to-back sum, 9+225+1+0 = 235
    push(16'h00EB, 1'b0);
    start_op();
    check("acc_ready", 32'(bus.oProductReady), 32'd1);
    send(16'h0009, 0);
    send(16'h00E1, 0);
    send(16'h0001, 0);
    check("pre_done_valid", 32'(bus.oSumValid), 32'd0);
    send(16'h0000, 0);
    check("latency_valid", 32'(bus.oSumValid), 32'd1);
    release_sum();

    // 3: products ignored in IDLE, then gapped transfers, 2+3+4+5 = 14
    bus.iProductValid = 1'b1;
    bus.iProduct      = 16'h0010;
    step();
    step();
    check("idle_ready", 32'(bus.oProductReady), 32'd0);
    check("idle_sum_held", 32'(bus.oSum), 32'h00EB);
    check("idle_busy", 32'(bus.oBusy), 32'd0);
    bus.iProductValid = 1'b0;
    push(16'h000E, 1'b0);
    start_op();
    send(16'h0002, 1);
    send(16'h0003, 2);
    check("gap_cnt", 32'(bus.oCount), 32'd2);
    send(16'h0004, 3);
    send(16'h0005, 1);
    release_sum();

    // 4: overflow then a clean operation clears the sticky flag
    push(16'h0001, 1'b1);
    start_op();
    send(16'h8000, 0);
    send(16'h8000, 0);
    check("ovf_sticky_mid", 32'(bus.oOverflow), 32'd1);
    send(16'h0001, 0);
    send(16'h0000, 0);
    release_sum();
    push(16'h000A, 1'b0);
    start_op();
    check("ovf_cleared_on_start", 32'(bus.oOverflow), 32'd0);
    send(16'h0001, 0);
    send(16'h0002, 0);
    send(16'h0003, 0);
    send(16'h0004, 0);
    release_sum();

    // 5: backpressure in DONE, 5+6+7+8 = 26
    push(16'h001A, 1'b0);
    start_op();
    send(16'h0005, 0);
    send(16'h0006, 0);
    send(16'h0007, 0);
    send(16'h0008, 0);
    for (int i = 0; i < 5; i++) begin
      bus.iStart        = i[0];
      bus.iProductValid = ~i[0];
      bus.iProduct      = 16'h00FF;
      step();
      check("bp_sum", 32'(bus.oSum), 32'h001A);
      check("bp_cnt", 32'(bus.oCount), 32'd4);
      check("bp_valid", 32'(bus.oSumValid), 32'd1);
    end
    bus.iStart = 1'b1;
    bus.iProductValid = 1'b0;
    release_sum();
    bus.iStart = 1'b0;
    step();
    check("start_ignored_in_done", 32'(bus.oBusy), 32'd0);

    // 6: reset mid-operation discards the partial sum
    start_op();
    send(16'h0007, 0);
    send(16'h0009, 0);
    check("mid_cnt", 32'(bus.oCount), 32'd2);
    Reset = 1'b0;
    step();
    check_all_zero("midreset");
    Reset = 1'b1;
    push(16'h0004, 1'b0);
    start_op();
    for (int i = 0; i < 4; i++) send(16'h0001, 0);
    release_sum();

    step();
    step();
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
